// File: rtl/core_pkg.sv
// Shared types and constants for the core tile sequencer and the inst word packer.
package core_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_KLOAD,
      S_KEXEC,
      S_KWAIT,
      S_ALOAD,
      S_EXEC,
      S_DRAIN,
      S_FIN
   } seq_state_t;

   localparam int INST_W       = 34;
   localparam int INST_ADDR_BW = 11;

   // Bit positions inside the 34-bit core inst word; bits [2:0] are reserved.
   localparam int INST_PMEM_CEN   = 33;
   localparam int INST_PMEM_WEN   = 32;
   localparam int INST_PMEM_A_LSB = 21;
   localparam int INST_XMEM_CEN   = 20;
   localparam int INST_XMEM_WEN   = 19;
   localparam int INST_XMEM_A_LSB = 8;
   localparam int INST_OFIFO_RD   = 7;
   localparam int INST_L0_RD      = 6;
   localparam int INST_L0_WR      = 5;
   localparam int INST_EXECUTE    = 4;
   localparam int INST_LOAD       = 3;

   localparam int SRAM_RD_LAT = 1;

endpackage

// File: rtl/core_inst_pack.sv
// Packs the sequencer control outputs into the 34-bit core inst word.
module core_inst_pack
   import core_pkg::*;
(
   input  logic                    xmem_cen,
   input  logic                    xmem_wen,
   input  logic [INST_ADDR_BW-1:0] xmem_addr,
   input  logic                    pmem_cen,
   input  logic                    pmem_wen,
   input  logic [INST_ADDR_BW-1:0] pmem_addr,
   input  logic                    load,
   input  logic                    execute,
   input  logic                    l0_wr,
   input  logic                    l0_rd,
   input  logic                    ofifo_rd,
   output logic [INST_W-1:0]       inst
);

   always_comb begin
      inst                                     = '0;
      inst[INST_PMEM_CEN]                      = pmem_cen;
      inst[INST_PMEM_WEN]                      = pmem_wen;
      inst[INST_PMEM_A_LSB +: INST_ADDR_BW]    = pmem_addr;
      inst[INST_XMEM_CEN]                      = xmem_cen;
      inst[INST_XMEM_WEN]                      = xmem_wen;
      inst[INST_XMEM_A_LSB +: INST_ADDR_BW]    = xmem_addr;
      inst[INST_OFIFO_RD]                      = ofifo_rd;
      inst[INST_L0_RD]                         = l0_rd;
      inst[INST_L0_WR]                         = l0_wr;
      inst[INST_EXECUTE]                       = execute;
      inst[INST_LOAD]                          = load;
   end

endmodule

// File: rtl/core_seq_ctrl.sv
// Per-tile sequencer: kernel load, activation load, execute, psum drain.
// Optional CORE_SEQ_PERF_EN adds saturating stall_cnt/cycle_cnt outputs.
module core_seq_ctrl
   import core_pkg::*;
#(
   parameter int row     = 8,
   parameter int col     = 8,
   parameter int ADDR_BW = 11,
   parameter int LEN_BW  = 11
)
(
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic [ADDR_BW-1:0] kern_base,
   input  logic [ADDR_BW-1:0] act_base,
   input  logic [ADDR_BW-1:0] psum_base,
   input  logic [LEN_BW-1:0]  num_act,
   output logic               busy,
   output logic               done,
   output logic               xmem_cen,
   output logic               xmem_wen,
   output logic [ADDR_BW-1:0] xmem_addr,
   output logic               l0_wr,
   output logic               l0_rd,
   input  logic               l0_full,
   output logic               load,
   output logic               execute,
   input  logic               ofifo_valid,
   output logic               ofifo_rd,
   output logic               pmem_cen,
   output logic               pmem_wen,
   output logic [ADDR_BW-1:0] pmem_addr,
   output logic [INST_W-1:0]  inst
`ifdef CORE_SEQ_PERF_EN
   ,
   output logic [15:0]        stall_cnt,
   output logic [15:0]        cycle_cnt
`endif
);

   localparam int CNT_BW = LEN_BW + 1;
   localparam logic [CNT_BW-1:0] ROW_C = CNT_BW'(row);
   localparam logic [CNT_BW-1:0] COL_C = CNT_BW'(col);

   seq_state_t               state_reg, state_next;
   logic [CNT_BW-1:0]        idx_reg, idx_next;
   logic [CNT_BW-1:0]        wait_reg, wait_next;
   logic [ADDR_BW-1:0]       kern_base_reg, act_base_reg, psum_base_reg;
   logic [LEN_BW-1:0]        num_act_reg;
   logic [SRAM_RD_LAT-1:0]   rd_pipe_reg;
   logic                     ofifo_rd_reg;
   logic [ADDR_BW-1:0]       pmem_addr_reg;
   logic                     issue;
   logic [CNT_BW-1:0]        len;
   logic [ADDR_BW-1:0]       load_base;

   assign len       = (state_reg == S_KLOAD) ? ROW_C : CNT_BW'(num_act_reg);
   assign load_base = (state_reg == S_KLOAD) ? kern_base_reg : act_base_reg;

   assign busy      = (state_reg != S_IDLE) && (state_reg != S_FIN);
   assign xmem_cen  = ~issue;
   assign xmem_wen  = 1'b1;
   assign l0_wr     = rd_pipe_reg[SRAM_RD_LAT-1];
   assign pmem_cen  = ~ofifo_rd_reg;
   assign pmem_wen  = ~ofifo_rd_reg;
   assign pmem_addr = pmem_addr_reg;

   always_comb begin
      state_next = state_reg;
      idx_next   = idx_reg;
      wait_next  = wait_reg;
      issue      = 1'b0;
      xmem_addr  = '0;
      l0_rd      = 1'b0;
      load       = 1'b0;
      execute    = 1'b0;
      ofifo_rd   = 1'b0;
      done       = 1'b0;
      case (state_reg)
         S_IDLE: begin
            if (start) begin
               state_next = S_KLOAD;
               idx_next   = '0;
               wait_next  = '0;
            end
         end
         S_KLOAD, S_ALOAD: begin
            // idx counts issued reads, wait counts words landed in L0.
            xmem_addr = load_base + ADDR_BW'(idx_reg);
            if (idx_reg != len && !l0_full) begin
               issue    = 1'b1;
               idx_next = idx_reg + 1'b1;
            end
            if (l0_wr) begin
               wait_next = wait_reg + 1'b1;
               if (wait_reg == len - 1'b1) begin
                  state_next = (state_reg == S_KLOAD) ? S_KEXEC : S_EXEC;
                  wait_next  = '0;
                  idx_next   = '0;
               end
            end
         end
         S_KEXEC: begin
            load      = 1'b1;
            l0_rd     = 1'b1;
            wait_next = wait_reg + 1'b1;
            if (wait_reg == ROW_C - 1'b1) begin
               state_next = S_KWAIT;
               wait_next  = '0;
            end
         end
         S_KWAIT: begin
            wait_next = wait_reg + 1'b1;
            if (wait_reg == COL_C - 1'b1) begin
               state_next = (num_act_reg == '0) ? S_FIN : S_ALOAD;
               wait_next  = '0;
               idx_next   = '0;
            end
         end
         S_EXEC: begin
            execute   = 1'b1;
            l0_rd     = 1'b1;
            wait_next = wait_reg + 1'b1;
            if (wait_reg == len - 1'b1) begin
               state_next = S_DRAIN;
               wait_next  = '0;
               idx_next   = '0;
            end
         end
         S_DRAIN: begin
            // Final cycle carries the pmem write of the last row read.
            if (idx_reg != len) begin
               if (ofifo_valid) begin
                  ofifo_rd = 1'b1;
                  idx_next = idx_reg + 1'b1;
               end
            end else begin
               state_next = S_FIN;
            end
         end
         S_FIN: begin
            done       = 1'b1;
            state_next = S_IDLE;
         end
         default: state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_reg     <= S_IDLE;
         idx_reg       <= '0;
         wait_reg      <= '0;
         kern_base_reg <= '0;
         act_base_reg  <= '0;
         psum_base_reg <= '0;
         num_act_reg   <= '0;
         rd_pipe_reg   <= '0;
         ofifo_rd_reg  <= 1'b0;
         pmem_addr_reg <= '0;
      end else begin
         state_reg    <= state_next;
         idx_reg      <= idx_next;
         wait_reg     <= wait_next;
         rd_pipe_reg  <= (rd_pipe_reg << 1) | SRAM_RD_LAT'(issue);
         ofifo_rd_reg <= ofifo_rd;
         if (ofifo_rd)
            pmem_addr_reg <= psum_base_reg + ADDR_BW'(idx_reg);
         if (state_reg == S_IDLE && start) begin
            kern_base_reg <= kern_base;
            act_base_reg  <= act_base;
            psum_base_reg <= psum_base;
            num_act_reg   <= num_act;
         end
      end
   end

`ifdef CORE_SEQ_PERF_EN
   logic stall;
   assign stall = (((state_reg == S_KLOAD) || (state_reg == S_ALOAD)) && idx_reg != len && l0_full)
                || ((state_reg == S_DRAIN) && idx_reg != len && !ofifo_valid);

   always_ff @(posedge clk) begin
      if (!reset) begin
         stall_cnt <= '0;
         cycle_cnt <= '0;
      end else if (state_reg == S_IDLE && start) begin
         stall_cnt <= '0;
         cycle_cnt <= '0;
      end else begin
         if (busy && cycle_cnt != 16'hFFFF)
            cycle_cnt <= cycle_cnt + 1'b1;
         if (stall && stall_cnt != 16'hFFFF)
            stall_cnt <= stall_cnt + 1'b1;
      end
   end
`endif

   core_inst_pack u_inst_pack (
      .xmem_cen  (xmem_cen),
      .xmem_wen  (xmem_wen),
      .xmem_addr (INST_ADDR_BW'(xmem_addr)),
      .pmem_cen  (pmem_cen),
      .pmem_wen  (pmem_wen),
      .pmem_addr (INST_ADDR_BW'(pmem_addr)),
      .load      (load),
      .execute   (execute),
      .l0_wr     (l0_wr),
      .l0_rd     (l0_rd),
      .ofifo_rd  (ofifo_rd),
      .inst      (inst)
   );

endmodule

// File: tb/tb_core_seq_ctrl.sv
// Directed bench for core_seq_ctrl: full tiles, L0/OFIFO backpressure, empty tile, wrap, abort.
module tb_core_seq_ctrl;

   logic        clk = 1'b0;
   logic        reset, start;
   logic [10:0] kern_base, act_base, psum_base;
   logic [10:0] num_act;
   logic        busy, done, xmem_cen, xmem_wen;
   logic [10:0] xmem_addr, pmem_addr;
   logic        l0_wr, l0_rd, l0_full, load, execute, ofifo_valid, ofifo_rd;
   logic        pmem_cen, pmem_wen;
   logic [33:0] inst;
`ifdef CORE_SEQ_PERF_EN
   logic [15:0] stall_cnt, cycle_cnt;
`endif

   always #5 clk = ~clk;

   core_seq_ctrl #(.row(8), .col(8), .ADDR_BW(11), .LEN_BW(11)) dut (
      .clk(clk), .reset(reset), .start(start),
      .kern_base(kern_base), .act_base(act_base), .psum_base(psum_base), .num_act(num_act),
      .busy(busy), .done(done),
      .xmem_cen(xmem_cen), .xmem_wen(xmem_wen), .xmem_addr(xmem_addr),
      .l0_wr(l0_wr), .l0_rd(l0_rd), .l0_full(l0_full),
      .load(load), .execute(execute),
      .ofifo_valid(ofifo_valid), .ofifo_rd(ofifo_rd),
      .pmem_cen(pmem_cen), .pmem_wen(pmem_wen), .pmem_addr(pmem_addr),
      .inst(inst)
`ifdef CORE_SEQ_PERF_EN
      , .stall_cnt(stall_cnt), .cycle_cnt(cycle_cnt)
`endif
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   int rd_q[$];
   int pm_q[$];
   int l0wr_cnt, load_cnt, exec_cnt, ord_cnt, busy_cyc, quiet_cyc, done_cnt;
   int bad_follow, bad_stall, bad_hold, bad_wr, bad_xwen, bad_rd, bad_inst, bad_pwen;
   bit got_done, busy_at_done, prev_issue, prev_ofifo_rd;

   task automatic clear_obs();
      rd_q.delete(); pm_q.delete();
      l0wr_cnt = 0; load_cnt = 0; exec_cnt = 0; ord_cnt = 0; busy_cyc = 0; quiet_cyc = 0;
      done_cnt = 0; bad_follow = 0; bad_stall = 0; bad_hold = 0; bad_wr = 0; bad_xwen = 0;
      bad_rd = 0; bad_inst = 0; bad_pwen = 0;
      got_done = 0; busy_at_done = 0; prev_issue = 0; prev_ofifo_rd = 0;
   endtask

   // Called #1 after a negedge; records one cycle of DUT activity.
   task automatic observe(input int kb, input int ab);
      int exp_next;
      exp_next = (rd_q.size() < 8) ? (kb + rd_q.size()) % 2048 : (ab + rd_q.size() - 8) % 2048;
      if (xmem_wen !== 1'b1) bad_xwen++;
      if (l0_full && xmem_cen !== 1'b1) bad_stall++;
      if (l0_full && xmem_addr !== 11'(exp_next)) bad_hold++;
      if (l0_wr !== prev_issue) bad_wr++;
      prev_issue = (xmem_cen === 1'b0);
      if (xmem_cen === 1'b0) rd_q.push_back(int'(xmem_addr));
      l0wr_cnt += int'(l0_wr);
      load_cnt += int'(load);
      exec_cnt += int'(execute);
      ord_cnt  += int'(ofifo_rd);
      if (ofifo_rd && !ofifo_valid) bad_rd++;
      if (pmem_cen === 1'b0) begin
         pm_q.push_back(int'(pmem_addr));
         if (!prev_ofifo_rd) bad_follow++;
         if (pmem_wen !== 1'b0) bad_pwen++;
      end else if (prev_ofifo_rd) begin
         bad_follow++;
      end
      prev_ofifo_rd = ofifo_rd;
      if (inst[3] !== load || inst[18:8] !== xmem_addr || inst[20] !== xmem_cen || inst[33] !== pmem_cen)
         bad_inst++;
      if (busy) busy_cyc++;
      if (busy && xmem_cen && !l0_wr && !l0_rd && !load && !execute && !ofifo_rd && pmem_cen)
         quiet_cyc++;
      if (done) begin
         done_cnt++;
         got_done     = 1;
         busy_at_done = busy;
      end
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, ":busy"}, busy, 0);
      check({tag, ":done"}, done, 0);
      check({tag, ":xmem_cen"}, xmem_cen, 1);
      check({tag, ":xmem_wen"}, xmem_wen, 1);
      check({tag, ":pmem_cen"}, pmem_cen, 1);
      check({tag, ":pmem_wen"}, pmem_wen, 1);
      check({tag, ":strobes"}, {l0_wr, l0_rd, load, execute, ofifo_rd}, 0);
      check({tag, ":xmem_addr"}, xmem_addr, 0);
      check({tag, ":pmem_addr"}, pmem_addr, 0);
      check({tag, ":inst"}, inst, 64'h3_0018_0000);
   endtask

   // full_lo..full_hi: cycles with l0_full high; vmode 1 gives ofifo_valid 1,0,0,...
   // s_a/s_b: cycles where a stray start is driven; -1 entries disable a feature.
   task automatic run_tile(input string name, input int kb, input int ab, input int pb, input int n,
                           input int full_lo, input int full_hi, input int vmode,
                           input int s_a, input int s_b, input int exp_busy, input int exp_quiet);
      clear_obs();
      @(negedge clk);
      start = 1; kern_base = 11'(kb); act_base = 11'(ab); psum_base = 11'(pb); num_act = 11'(n);
      @(negedge clk);
      start = 0; kern_base = 11'h5A5; act_base = 11'h3C3; psum_base = 11'h111; num_act = 11'd7;
      for (int c = 0; c < 600; c++) begin
         l0_full     = (c >= full_lo && c <= full_hi);
         ofifo_valid = (vmode == 0) ? 1'b1 : (c % 3 == 0);
         start       = (c == s_a) || (c == s_b);
         #1;
         observe(kb, ab);
         @(negedge clk);
         if (got_done) break;
      end
      start = 0; l0_full = 0; ofifo_valid = 1;
      #1;
      check({name, ":idle_after_done"}, busy, 0);
      check({name, ":done"}, got_done, 1);
      check({name, ":done_cnt"}, done_cnt, 1);
      check({name, ":busy_at_done"}, busy_at_done, 0);
      check({name, ":reads"}, rd_q.size(), 8 + n);
      for (int i = 0; i < rd_q.size() && i < 8 + n; i++)
         check({name, ":xaddr"}, rd_q[i], (i < 8) ? (kb + i) % 2048 : (ab + i - 8) % 2048);
      check({name, ":l0_wr"}, l0wr_cnt, 8 + n);
      check({name, ":load"}, load_cnt, 8);
      check({name, ":execute"}, exec_cnt, n);
      check({name, ":ofifo_rd"}, ord_cnt, n);
      check({name, ":pmem_writes"}, pm_q.size(), n);
      for (int j = 0; j < pm_q.size() && j < n; j++)
         check({name, ":paddr"}, pm_q[j], (pb + j) % 2048);
      check({name, ":pmem_follow"}, bad_follow, 0);
      check({name, ":cen_in_stall"}, bad_stall, 0);
      check({name, ":addr_hold"}, bad_hold, 0);
      check({name, ":l0_wr_lat"}, bad_wr, 0);
      check({name, ":xmem_wen"}, bad_xwen, 0);
      check({name, ":pmem_wen"}, bad_pwen, 0);
      check({name, ":rd_no_valid"}, bad_rd, 0);
      check({name, ":inst_map"}, bad_inst, 0);
      if (exp_busy >= 0) check({name, ":busy_cycles"}, busy_cyc, exp_busy);
      if (exp_quiet >= 0) check({name, ":kwait_idle"}, quiet_cyc, exp_quiet);
      $display("tile %s kb=%0d ab=%0d pb=%0d n=%0d busy=%0d reads=%0d pmem=%0d done=%0d",
               name, kb, ab, pb, n, busy_cyc, rd_q.size(), pm_q.size(), got_done);
   endtask

   initial begin
      int d_cnt, b_cnt;
      bit seen;
      reset = 0; start = 0; l0_full = 0; ofifo_valid = 1;
      kern_base = 0; act_base = 0; psum_base = 0; num_act = 0;
      repeat (2) @(negedge clk);
      #1;
      check_reset_state("reset");
      reset = 1;

      run_tile("basic",   0,    8,    0,   4, -1, -1, 0,  3, 39, 39, 8);
      run_tile("l0_bp",   100,  200,  300, 3,  2,  4, 0, -1, -1, 39, -1);
      run_tile("ofifo",   16,   40,   100, 5, -1, -1, 1, -1, -1, -1, -1);
      run_tile("empty",   8,    0,    50,  0, -1, -1, 0, -1, -1, 25, 8);
      run_tile("wrap",    2040, 2046, 2046, 4, -1, -1, 0, -1, -1, 39, 8);

      // Abort in EXEC, then confirm a clean restart.
      @(negedge clk);
      start = 1; kern_base = 0; act_base = 8; psum_base = 0; num_act = 4;
      @(negedge clk);
      start = 0;
      seen = 0;
      for (int c = 0; c < 100; c++) begin
         #1;
         if (execute === 1'b1) begin
            seen = 1;
            break;
         end
         @(negedge clk);
      end
      check("abort:exec_seen", seen, 1);
      reset = 0;
      @(negedge clk);
      #1;
      check_reset_state("abort");
      @(negedge clk);
      reset = 1;
      d_cnt = 0; b_cnt = 0;
      for (int c = 0; c < 40; c++) begin
         #1;
         d_cnt += int'(done);
         b_cnt += int'(busy);
         @(negedge clk);
      end
      check("abort:no_done", d_cnt, 0);
      check("abort:no_busy", b_cnt, 0);
      $display("abort during EXEC: done pulses=%0d busy cycles=%0d", d_cnt, b_cnt);

      run_tile("restart", 24, 500, 7, 6, -1, -1, 0, -1, -1, 45, 8);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
